// File: rtl/timer_chain_reader.sv
// Master-side reader for the daisy-chained timer capture registers: drives the
// shift clock, reassembles LSB-first words and re-arms the chain when finished.
module timer_chain_reader #(
  parameter int WORD_WIDTH = 32,
  parameter int NUM_WORDS  = 4,
  parameter int CLK_DIV    = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         abort,
  input  logic                         chain_ready,
  input  logic                         serial_in,
  output logic                         data_clock,
  output logic                         chain_rearm_n,
  output logic                         busy,
  output logic                         word_valid,
  output logic [$clog2(NUM_WORDS)-1:0] word_index,
  output logic [WORD_WIDTH-1:0]        word_data,
  output logic                         done
);

  localparam int IW = $clog2(NUM_WORDS);
  localparam int DW = $clog2(2 * CLK_DIV + 1);
  localparam int BW = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;

  localparam logic [DW-1:0] LAST_DIV  = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] REARM_END = DW'(2 * CLK_DIV);
  localparam logic [BW-1:0] LAST_BIT  = BW'(WORD_WIDTH - 1);
  localparam logic [IW-1:0] LAST_WORD = IW'(NUM_WORDS - 1);

  typedef enum logic [2:0] {IDLE, ARMED, LOW, HIGH, REARM} state_t;

  state_t                state, state_nxt;
  logic [DW-1:0]         div_cnt;
  logic [BW-1:0]         bit_cnt;
  logic [IW-1:0]         word_cnt;
  logic [WORD_WIDTH-1:0] sh;

  logic phase_end, word_end, last_word;

  assign phase_end = (div_cnt == LAST_DIV);
  assign word_end  = (bit_cnt == LAST_BIT);
  assign last_word = (word_cnt == LAST_WORD);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start && !abort) state_nxt = ARMED;
      ARMED: if (abort) state_nxt = IDLE;
             else if (chain_ready) state_nxt = LOW;
      LOW:   if (abort) state_nxt = IDLE;
             else if (phase_end) state_nxt = HIGH;
      HIGH:  if (abort) state_nxt = IDLE;
             else if (phase_end) state_nxt = (word_end && last_word) ? REARM : LOW;
      REARM: if (abort || div_cnt == REARM_END) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // REARM holds the line low for 2*CLK_DIV cycles, then one released cycle before done.
  always_comb begin
    data_clock    = (state == HIGH);
    chain_rearm_n = !((state == REARM) && (div_cnt < REARM_END));
    busy          = (state != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt    <= '0;
      bit_cnt    <= '0;
      word_cnt   <= '0;
      sh         <= '0;
      word_valid <= 1'b0;
      word_index <= '0;
      word_data  <= '0;
      done       <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      done       <= 1'b0;
      if (state == IDLE || state == ARMED || abort) begin
        div_cnt  <= '0;
        bit_cnt  <= '0;
        word_cnt <= '0;
      end else begin
        case (state)
          LOW: begin
            if (phase_end) begin
              sh      <= {serial_in, sh[WORD_WIDTH-1:1]};
              div_cnt <= '0;
            end else begin
              div_cnt <= div_cnt + DW'(1);
            end
          end
          HIGH: begin
            if (phase_end) begin
              div_cnt <= '0;
              if (word_end) begin
                word_data  <= sh;
                word_index <= word_cnt;
                word_valid <= 1'b1;
                bit_cnt    <= '0;
                word_cnt   <= last_word ? '0 : word_cnt + IW'(1);
              end else begin
                bit_cnt <= bit_cnt + BW'(1);
              end
            end else begin
              div_cnt <= div_cnt + DW'(1);
            end
          end
          REARM: begin
            if (div_cnt == REARM_END) begin
              div_cnt <= '0;
              done    <= 1'b1;
            end else begin
              div_cnt <= div_cnt + DW'(1);
            end
          end
          default: div_cnt <= '0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_timer_chain_reader.sv
// Bench for timer_chain_reader: behavioural capture chain, timeline model of the
// reader checked every cycle, plus directed scenarios with literal expectations.
module tb_timer_chain_reader;

  localparam int WW  = 8;
  localparam int NW  = 2;
  localparam int CD  = 4;
  localparam int BITP  = 2 * CD;
  localparam int WORDP = WW * BITP;
  localparam int SHIFT = NW * WORDP;
  localparam int TDONE = SHIFT + BITP + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          chain_ready;
  logic          serial_in;
  logic          data_clock;
  logic          chain_rearm_n;
  logic          busy;
  logic          word_valid;
  logic [0:0]    word_index;
  logic [WW-1:0] word_data;
  logic          done;

  timer_chain_reader #(.WORD_WIDTH(WW), .NUM_WORDS(NW), .CLK_DIV(CD)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .chain_ready(chain_ready), .serial_in(serial_in),
    .data_clock(data_clock), .chain_rearm_n(chain_rearm_n), .busy(busy),
    .word_valid(word_valid), .word_index(word_index), .word_data(word_data),
    .done(done)
  );

  always #5 clk = ~clk;

  // Capture chain: negedge logic, 2-flop synchroniser on data_clock, shifts toward the reader.
  logic             load_req = 1'b0;
  logic [NW*WW-1:0] load_val = '0;
  logic [NW*WW-1:0] chain = '0;
  logic             ready = 1'b0;
  logic             s1 = 1'b0, s2 = 1'b0, s_prev = 1'b0;

  always @(negedge clk) begin
    if (load_req) begin
      chain  <= load_val;
      ready  <= 1'b1;
      s1     <= 1'b0;
      s2     <= 1'b0;
      s_prev <= 1'b0;
    end else begin
      s1     <= data_clock;
      s2     <= s1;
      s_prev <= s2;
      if (s2 && !s_prev) chain <= chain >> 1;
      if (!chain_rearm_n) ready <= 1'b0;
    end
  end

  assign chain_ready = ready;
  assign serial_in   = chain[0];

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model and observation state
  logic [WW-1:0] exp_word [NW];
  int mode = 0;          // 0 idle, 1 waiting for ready, 2 running from LOW entry L
  int L = 0;
  int cyc = 0;
  int rdy_cyc = 0;
  int n_rise = 0, n_valid = 0, n_done = 0, n_rlow = 0;
  int last_valid_cyc = 0, last_done_cyc = 0, first_rise = 0;
  bit arm_rise = 0;
  logic done_busy = 1'b1;
  logic prev_dc = 1'b0;
  logic [WW-1:0] cap_d [$];
  int            cap_i [$];

  task automatic monitor();
    int d, k;
    logic e_dc, e_rn, e_busy, e_wv, e_done;
    forever begin
      @(posedge clk);
      if (reset) mode = 0;
      else begin
        if (mode == 2 && cyc - L >= TDONE) mode = 0;
        case (mode)
          0: if (start && !abort) mode = 1;
          1: if (abort) mode = 0;
             else if (chain_ready) begin mode = 2; L = cyc + 1; rdy_cyc = cyc; end
          default: if (abort) mode = 0;
        endcase
      end
      cyc++;
      @(negedge clk);
      e_dc = 0; e_rn = 1; e_busy = 0; e_wv = 0; e_done = 0; k = 0;
      if (reset) mode = 0;
      else if (mode == 1) e_busy = 1;
      else if (mode == 2) begin
        d      = cyc - L;
        e_dc   = (d < SHIFT) && ((d % BITP) >= CD);
        e_wv   = (d > 0) && (d <= SHIFT) && (d % WORDP == 0);
        k      = d / WORDP - 1;
        e_rn   = !(d >= SHIFT && d < SHIFT + BITP);
        e_done = (d == TDONE);
        e_busy = (d < TDONE);
      end
      chk("data_clock", data_clock, e_dc);
      chk("chain_rearm_n", chain_rearm_n, e_rn);
      chk("busy", busy, e_busy);
      chk("word_valid", word_valid, e_wv);
      chk("done", done, e_done);
      if (e_wv && k >= 0 && k < NW) begin
        chk("word_data", word_data, exp_word[k]);
        chk("word_index", word_index, k);
      end
      if (data_clock && !prev_dc) begin
        n_rise++;
        if (arm_rise) begin first_rise = cyc; arm_rise = 0; end
      end
      prev_dc = data_clock;
      if (word_valid) begin
        n_valid++; last_valid_cyc = cyc;
        cap_d.push_back(word_data); cap_i.push_back(int'(word_index));
      end
      if (done) begin n_done++; last_done_cyc = cyc; done_busy = busy; end
      if (!chain_rearm_n) n_rlow++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic load(input logic [WW-1:0] nearw, input logic [WW-1:0] farw);
    exp_word[0] = nearw;
    exp_word[1] = farw;
    load_val = {farw, nearw};
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    int snap = n_done;
    for (int i = 0; i < bound && n_done == snap; i++) tick();
    chk("done_reached", (n_done != snap), 1'b1);
  endtask

  task automatic check_words(input string tag, input logic [WW-1:0] w0, input logic [WW-1:0] w1);
    chk({tag, "_count"}, cap_d.size(), 2);
    if (cap_d.size() >= 2) begin
      chk({tag, "_w0"}, cap_d[0], w0);
      chk({tag, "_i0"}, cap_i[0], 0);
      chk({tag, "_w1"}, cap_d[1], w1);
      chk({tag, "_i1"}, cap_i[1], 1);
    end
  endtask

  task automatic run_tests();
    int sr, sv, sd, sl;
    exp_word[0] = '0;
    exp_word[1] = '0;
    repeat (3) tick();
    chk("rst_data_clock", data_clock, 1'b0);
    chk("rst_rearm_n", chain_rearm_n, 1'b1);
    chk("rst_index", word_index, 0);
    chk("rst_data", word_data, 0);
    reset = 1'b0;
    tick();

    // Normal read with a second start pulse while busy
    load(8'hA5, 8'h3C);
    cap_d.delete(); cap_i.delete();
    sr = n_rise; sv = n_valid; sd = n_done; sl = n_rlow;
    pulse_start();
    repeat (20) tick();
    pulse_start();
    wait_done(400);
    repeat (3) tick();
    check_words("t1", 8'hA5, 8'h3C);
    chk("t1_rises", n_rise - sr, 16);
    chk("t1_valids", n_valid - sv, 2);
    chk("t1_dones", n_done - sd, 1);
    chk("t1_rearm_low", n_rlow - sl, 8);
    chk("t1_done_gap", last_done_cyc - last_valid_cyc, 9);
    chk("t1_done_busy", done_busy, 1'b0);
    chk("t1_chain_cleared", chain_ready, 1'b0);

    // Start while the chain is not ready
    sr = n_rise;
    cap_d.delete(); cap_i.delete();
    pulse_start();
    repeat (50) tick();
    chk("t2_busy_wait", busy, 1'b1);
    chk("t2_no_clock", n_rise - sr, 0);
    arm_rise = 1;
    load(8'h5A, 8'hC3);
    wait_done(400);
    chk("t2_first_rise", first_rise - rdy_cyc, 5);
    check_words("t2", 8'h5A, 8'hC3);

    // Abort during bit 5 of word 0
    load(8'h96, 8'h69);
    sr = n_rise; sv = n_valid; sd = n_done; sl = n_rlow;
    pulse_start();
    for (int i = 0; i < 200 && (n_rise - sr) < 6; i++) tick();
    chk("t4_reached_bit5", n_rise - sr, 6);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t4_dc_after_abort", data_clock, 1'b0);
    chk("t4_busy_after_abort", busy, 1'b0);
    repeat (100) tick();
    chk("t4_no_valid", n_valid - sv, 0);
    chk("t4_no_done", n_done - sd, 0);
    chk("t4_no_rearm", n_rlow - sl, 0);

    // start and abort together in IDLE
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    tick();
    chk("t_start_abort_busy", busy, 1'b0);

    // Asynchronous reset while data_clock is high
    load(8'h11, 8'h22);
    sr = n_rise;
    pulse_start();
    for (int i = 0; i < 200 && !((n_rise - sr) >= 3 && data_clock); i++) tick();
    chk("t5_in_high", data_clock, 1'b1);
    reset = 1'b1;
    #1;
    chk("t5_async_dc", data_clock, 1'b0);
    chk("t5_async_busy", busy, 1'b0);
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("t5_rst_index", word_index, 0);
    chk("t5_rst_data", word_data, 0);
    chk("t5_rst_valid", word_valid, 1'b0);
    chk("t5_rst_rearm_n", chain_rearm_n, 1'b1);
    load(8'hFF, 8'h00);
    cap_d.delete(); cap_i.delete();
    pulse_start();
    wait_done(400);
    check_words("t5", 8'hFF, 8'h00);
    repeat (5) tick();
  endtask

  initial begin
    fork
      monitor();
      run_tests();
    join_any
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/timer_chain_reader.md
# timer_chain_reader

Master-side reader for the daisy-chained timer output registers. Waits for the chain to report a capture as ready, then generates the serial shift clock and samples the chain's serial output. It reassembles NUM_WORDS words of WORD_WIDTH bits, LSB first, and presents each word with a one-cycle valid strobe. It sits between the timer capture chain and the host-facing readout logic, and finishes by pulsing the chain's re-arm line.

## Interface
- WORD_WIDTH, 32: bits per chained register.
- NUM_WORDS, 4: registers in the chain.
- CLK_DIV, 8: clk cycles per half-period of data_clock. Must be at least 4, to cover the chain's 2-flop synchroniser plus the shift update.
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to read one capture.
- abort  in  1  cancels any transfer and returns to IDLE.
- chain_ready  in  1  AND of all chain data_ready flags.
- serial_in  in  1  data_shiftout of the register nearest the reader.
- data_clock  out  1  shift clock to the chain.
- chain_rearm_n  out  1  active-low clear/re-arm to the chain.
- busy  out  1  high in any state other than IDLE.
- word_valid  out  1  one-cycle strobe; word_data/word_index are valid.
- word_index  out  $clog2(NUM_WORDS)  0 = register nearest the reader.
- word_data  out  WORD_WIDTH  reassembled word.
- done  out  1  one-cycle strobe when the whole capture is read and re-armed.

## Operation
- States: IDLE, ARMED, LOW, HIGH, REARM.
- IDLE:
  - data_clock=0, chain_rearm_n=1.
  - A start pulse moves to ARMED.
  - start is ignored in every other state.
- ARMED:
  - Waits, with no timeout, for chain_ready=1, then goes to LOW.
  - abort returns to IDLE.
- LOW:
  - data_clock=0 for CLK_DIV cycles.
  - In the last LOW cycle, sample serial_in into the shift register: sh <= {serial_in, sh[WORD_WIDTH-1:1]}.
  - Then go to HIGH.
- HIGH:
  - data_clock=1 for CLK_DIV cycles. The chain shifts by one bit on this rising edge.
  - At the end of HIGH, if the bit counter equals WORD_WIDTH-1:
    - word_data<=sh and word_valid=1 for one cycle;
    - word_index increments;
    - the bit counter clears.
  - Otherwise the bit counter increments.
  - After the last bit of the last word, go to REARM; otherwise go to LOW.
- Bit 0 of the nearest register is present on serial_in before the first rising edge. Every bit, including the final one, gets a full LOW+HIGH period, so the chain is fully shifted (NUM_WORDS*WORD_WIDTH rising edges).
- REARM:
  - chain_rearm_n=0 for 2*CLK_DIV cycles, then done=1 for one cycle and return to IDLE.
  - busy drops in the same cycle done is high.
- Abort in LOW, HIGH or REARM:
  - Next cycle: IDLE, data_clock=0, chain_rearm_n=1.
  - No word_valid or done is issued for the partial word.
  - Counters clear.
- Word order: word_index 0 is the register nearest the reader, then increasing toward the far end of the chain.

## Timing
- Reset values:
  - data_clock=0, chain_rearm_n=1, busy=0, word_valid=0, done=0;
  - word_index=0, word_data=0.
  - Internal counters and sh are cleared.
- Reset asserted mid-transfer forces these values immediately (asynchronously).
- start in cycle 0 → ARMED and busy=1 in cycle 1.
- If chain_ready=1 in cycle 1, LOW starts in cycle 2 and the first data_clock rise occurs in cycle 2+CLK_DIV.
- Bit period is 2*CLK_DIV cycles. A word takes WORD_WIDTH*2*CLK_DIV cycles.
- word_valid for word k is high in the first cycle after the last HIGH phase of word k (the cycle data_clock returns to 0, or the first REARM cycle for the final word).
- done follows the last word_valid by 2*CLK_DIV+1 cycles.
- Total from LOW entry to done: NUM_WORDS*WORD_WIDTH*2*CLK_DIV + 2*CLK_DIV + 1 cycles.
- chain_ready deasserting after ARMED has been left is ignored.
- abort and start in the same cycle: abort wins and the state is IDLE.

## Test plan
All tests use WORD_WIDTH=8, NUM_WORDS=2, CLK_DIV=4, with a behavioural chain model (negedge, 2-flop sync, LSB-first shift).
- Chain loaded with near=0xA5, far=0x3C; start, chain_ready=1 → word_valid idx0=0xA5, then idx1=0x3C. Exactly 16 data_clock rises, each high 4 cycles and low 4 cycles.
- start with chain_ready=0 for 50 cycles, then 1 → busy=1 throughout, data_clock stays 0 until ready; first rise occurs 5 cycles after chain_ready is sampled high.
- Normal completion → chain_rearm_n low for exactly 8 cycles; done high 9 cycles after the last word_valid; busy=0 in the done cycle; chain model data_ready cleared.
- abort asserted during bit 5 of word 0 → data_clock=0 and busy=0 next cycle; no word_valid, no done, chain_rearm_n never pulses.
- reset asserted during HIGH → data_clock falls without waiting for clk. After release, start re-reads a freshly loaded 0xFF/0x00 correctly.
- Second start pulse while busy → ignored; exactly 2 word_valid pulses and 1 done.
